tomasulo_regfile: RTL and testbench
===================================

# tomasulo_regfile

Parametrised architectural register file with an integrated register-status (Qi tag) table for the Tomasulo core. It sits between the issue stage and the reservation stations. It provides NRD combinational read ports that return value, busy flag and producer tag. It renames a destination register at issue, and it captures results from NWB common-data-bus (CDB) ports when the broadcast tag matches the register's pending tag.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, register count (power of two); register 0 hard-wired to zero
- NRD, 4, read ports
- NWB, 2, CDB write-back ports
- TAG_W, 4, producer tag width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state updates on rising edge
  - rst_n  in  1  asynchronous active-low reset
- Read ports:
  - rd_addr  in  NRD×log2(NREG)  read addresses
  - rd_data  out  NRD×XLEN  register values
  - rd_busy  out  NRD  register awaiting a producer
  - rd_tag  out  NRD×TAG_W  pending producer tag; 0 when not busy
- Issue (rename):
  - iss_valid  in  1  rename request
  - iss_rd  in  log2(NREG)  destination register
  - iss_tag  in  TAG_W  producer tag assigned
- CDB:
  - cdb_valid  in  NWB  broadcast valid
  - cdb_tag  in  NWB×TAG_W  broadcast tag
  - cdb_data  in  NWB×XLEN  broadcast value
- Flush and debug:
  - flush  in  1  squash all pending renames
  - dbg_addr  in  log2(NREG)  debug read address
  - dbg_data  out  XLEN  debug read value, no bypass

## Operation
- Reset: all values 0, all busy 0, all tags 0. Outputs follow combinationally: rd_data/rd_busy/rd_tag/dbg_data = 0.
- Register 0: reads return 0, busy 0, tag 0. Issue and CDB writes to it are ignored.
- CDB capture: for each register r with busy[r], a match on port k means cdb_valid[k] && cdb_tag[k]==tag[r]. On a match, value[r] takes cdb_data[k] and busy[r] clears. If several ports match, the lowest k wins.
- Issue: iss_valid && iss_rd!=0 sets busy[iss_rd]=1 and tag[iss_rd]=iss_tag.
- Issue and CDB match on the same register in the same cycle: value[r] is written with the CDB data, and busy stays 1 with the new iss_tag.
- Flush: clears every busy bit and tag, and keeps values. In a flush cycle, issue and CDB are ignored entirely.
- Reads see pre-edge state. A same-cycle issue is not visible to reads, because the issue stage resolves its own sources first.
- Tags are opaque. No tag uniqueness is checked; a duplicate tag in flight updates every matching register.

## Timing
- Reads: zero-latency combinational.
- Issue, CDB capture and flush: take effect at the next rising edge and are visible the following cycle.
- rst_n assertion mid-operation clears state immediately, independent of clk. Release is synchronous to the next edge by system convention.
- No handshake; all inputs are single-cycle qualified by their valid signals.

## Configuration
- Macro: REGFILE_CDB_BYPASS_EN.
- Defined: a read of a busy register whose tag matches a valid CDB port in the same cycle returns rd_data=cdb_data (lowest matching port), rd_busy=0 and rd_tag=0. This bypass is suppressed when flush=1.
- Undefined: reads reflect stored state only. Consumers must snoop the CDB themselves.
- dbg_data never bypasses.

## Structure
- Package tomasulo_rf_pkg:
  - Types: tag_t, cdb_pkt_t (valid, tag, data).
  - Constant: TAG_NONE = 0.
  - Function: lowest-index match priority.
- Sub-module rf_cdb_match:
  - Inputs: one pending tag, its busy flag and the NWB CDB bus.
  - Outputs: hit and selected data.
  - Instantiated once per register for capture and once per read port for bypass.

## Test plan
- Reset with all inputs idle:
  - every rd_data, rd_busy, rd_tag and dbg_data reads 0.
- Issue x5 tag 3, then the next cycle CDB port 1 sends tag 3 with data 0xDEADBEEF:
  - x5 reads busy=1, tag=3 in between.
  - Afterwards it reads 0xDEADBEEF, busy=0.
- Issue x7 tag 2, then CDB tag 2 (0x11) and issue x7 tag 9 in the same cycle:
  - next cycle x7 value=0x11, busy=1, tag=9.
  - A later CDB tag 2 does not change x7.
- Both CDB ports send tag 4 (port0 0xAA, port1 0xBB) to busy x3:
  - x3 = 0xAA.
- Issue x0 tag 1, plus CDB tag 1:
  - x0 stays 0 and not busy.
- x9 busy tag 6; flush with CDB tag 6 (0x55) the same cycle:
  - x9 busy=0 and keeps its old value.
  - With REGFILE_CDB_BYPASS_EN, a read of busy x9 during a tag-6 CDB cycle without flush returns 0x55, busy=0 in that same cycle.

Source files
------------

// File: rtl/tomasulo_rf_pkg.sv
// rtl/tomasulo_rf_pkg.sv - shared types, constants and CDB priority helper for tomasulo_regfile
// Contents:
//   tag_t      default-width producer tag
//   cdb_pkt_t  one CDB broadcast (valid, tag, data) at default widths
//   TAG_NONE   tag value reported for registers that are not busy
//   lowest_onehot  isolates the lowest set bit (lowest CDB port wins)
package tomasulo_rf_pkg;

    localparam int TAG_W_DEF = 4;
    localparam int XLEN_DEF  = 32;
    localparam int MAX_PORTS = 16;

    typedef logic [TAG_W_DEF-1:0] tag_t;

    localparam tag_t TAG_NONE = '0;

    typedef struct packed {
        logic                valid;
        tag_t                tag;
        logic [XLEN_DEF-1:0] data;
    } cdb_pkt_t;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [MAX_PORTS-1:0] lowest_onehot(input logic [MAX_PORTS-1:0] v);
        return v & (~v + MAX_PORTS'(1));
    endfunction

endpackage

// File: rtl/rf_cdb_match.sv
// rtl/rf_cdb_match.sv - matches one pending tag against all CDB ports, lowest port wins
// Ports:
//   tag        pending producer tag of the register / read operand
//   busy       pending tag is live; no hit is reported when low
//   cdb_valid  per-port broadcast valid
//   cdb_tag    per-port broadcast tag
//   cdb_data   per-port broadcast value
//   hit        at least one valid port carries the pending tag
//   data       value from the lowest-index matching port (0 when no hit)
module rf_cdb_match
    import tomasulo_rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NWB   = 2,
    parameter int TAG_W = 4
) (
    input  logic [TAG_W-1:0]           tag,
    input  logic                       busy,
    input  logic [NWB-1:0]             cdb_valid,
    input  logic [NWB-1:0][TAG_W-1:0]  cdb_tag,
    input  logic [NWB-1:0][XLEN-1:0]   cdb_data,
    output logic                       hit,
    output logic [XLEN-1:0]            data
);

    logic [NWB-1:0]       match;
    logic [MAX_PORTS-1:0] match_ext;
    logic [MAX_PORTS-1:0] sel;

    always_comb begin
        match     = '0;
        match_ext = '0;
        data      = '0;
        for (int k = 0; k < NWB; k++) begin
            match[k] = busy && cdb_valid[k] && (cdb_tag[k] == tag);
        end
        match_ext[NWB-1:0] = match;
        sel = lowest_onehot(match_ext);
        // sel is one-hot, so the OR reduces to a mux.
        for (int k = 0; k < NWB; k++) begin
            if (sel[k]) begin
                data = data | cdb_data[k];
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/tomasulo_regfile.sv
// rtl/tomasulo_regfile.sv - architectural register file with Qi tag table, CDB capture and rename
// Optional feature macro: REGFILE_CDB_BYPASS_EN (same-cycle CDB forwarding on read ports)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_addr/rd_data/rd_busy/rd_tag  NRD combinational read ports (tag 0 when not busy)
//   iss_valid/iss_rd/iss_tag    rename of a destination register at issue
//   cdb_valid/cdb_tag/cdb_data  NWB common-data-bus write-back ports
//   flush                       drop every pending rename, keep values
//   dbg_addr/dbg_data           debug read of stored value, never bypassed
module tomasulo_regfile
    import tomasulo_rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NRD   = 4,
    parameter int NWB   = 2,
    parameter int TAG_W = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NRD-1:0][$clog2(NREG)-1:0]  rd_addr,
    output logic [NRD-1:0][XLEN-1:0]          rd_data,
    output logic [NRD-1:0]                    rd_busy,
    output logic [NRD-1:0][TAG_W-1:0]         rd_tag,
    input  logic                              iss_valid,
    input  logic [$clog2(NREG)-1:0]           iss_rd,
    input  logic [TAG_W-1:0]                  iss_tag,
    input  logic [NWB-1:0]                    cdb_valid,
    input  logic [NWB-1:0][TAG_W-1:0]         cdb_tag,
    input  logic [NWB-1:0][XLEN-1:0]          cdb_data,
    input  logic                              flush,
    input  logic [$clog2(NREG)-1:0]           dbg_addr,
    output logic [XLEN-1:0]                   dbg_data
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  value_q [NREG];
    logic             busy_q  [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];

    logic             cap_hit  [NREG];
    logic [XLEN-1:0]  cap_data [NREG];

    // One matcher per register; x0 never becomes busy so its matcher never hits.
    for (genvar r = 0; r < NREG; r++) begin : g_cap
        rf_cdb_match #(
            .XLEN  (XLEN),
            .NWB   (NWB),
            .TAG_W (TAG_W)
        ) u_match (
            .tag       (tag_q[r]),
            .busy      (busy_q[r]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .hit       (cap_hit[r]),
            .data      (cap_data[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                busy_q[r]  <= 1'b0;
                tag_q[r]   <= '0;
            end
        end else if (flush) begin
            for (int r = 1; r < NREG; r++) begin
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else begin
            // x0 is skipped entirely, so it keeps its reset contents forever.
            for (int r = 1; r < NREG; r++) begin
                if (cap_hit[r]) begin
                    value_q[r] <= cap_data[r];
                    busy_q[r]  <= 1'b0;
                    tag_q[r]   <= '0;
                end
                // A rename in the same cycle overrides the capture's busy/tag clear
                // while the captured value is still kept.
                if (iss_valid && (iss_rd == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= iss_tag;
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [XLEN-1:0]  st_data;
        logic             st_busy;
        logic [TAG_W-1:0] st_tag;

        always_comb begin
            st_data = value_q[rd_addr[p]];
            st_busy = busy_q[rd_addr[p]];
            st_tag  = st_busy ? tag_q[rd_addr[p]] : TAG_W'(TAG_NONE);
        end

`ifdef REGFILE_CDB_BYPASS_EN
        logic            bp_hit;
        logic [XLEN-1:0] bp_data;

        rf_cdb_match #(
            .XLEN  (XLEN),
            .NWB   (NWB),
            .TAG_W (TAG_W)
        ) u_bypass (
            .tag       (tag_q[rd_addr[p]]),
            .busy      (st_busy && !flush),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .hit       (bp_hit),
            .data      (bp_data)
        );

        always_comb begin
            if (bp_hit) begin
                rd_data[p] = bp_data;
                rd_busy[p] = 1'b0;
                rd_tag[p]  = TAG_W'(TAG_NONE);
            end else begin
                rd_data[p] = st_data;
                rd_busy[p] = st_busy;
                rd_tag[p]  = st_tag;
            end
        end
`else
        always_comb begin
            rd_data[p] = st_data;
            rd_busy[p] = st_busy;
            rd_tag[p]  = st_tag;
        end
`endif
    end

    assign dbg_data = value_q[dbg_addr];

endmodule

// File: tb/tb_tomasulo_regfile.sv
// tb/tb_tomasulo_regfile.sv - directed self-checking bench for tomasulo_regfile
module tb_tomasulo_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 4;
    localparam int NWB   = 2;
    localparam int TAG_W = 4;
    localparam int AW    = $clog2(NREG);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NRD-1:0][AW-1:0]     rd_addr;
    logic [NRD-1:0][XLEN-1:0]   rd_data;
    logic [NRD-1:0]             rd_busy;
    logic [NRD-1:0][TAG_W-1:0]  rd_tag;
    logic                       iss_valid;
    logic [AW-1:0]              iss_rd;
    logic [TAG_W-1:0]           iss_tag;
    logic [NWB-1:0]             cdb_valid;
    logic [NWB-1:0][TAG_W-1:0]  cdb_tag;
    logic [NWB-1:0][XLEN-1:0]   cdb_data;
    logic                       flush;
    logic [AW-1:0]              dbg_addr;
    logic [XLEN-1:0]            dbg_data;

    int checks = 0;
    int errors = 0;

    tomasulo_regfile #(
        .XLEN (XLEN), .NREG (NREG), .NRD (NRD), .NWB (NWB), .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .rd_tag    (rd_tag),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .flush     (flush),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // Read register a on port p and compare value, busy and tag.
    task automatic chk_rd(input string nm, input int p, input int a,
                          input logic [XLEN-1:0] ed, input logic eb, input logic [TAG_W-1:0] et);
        rd_addr[p] = AW'(a);
        #1;
        chk({nm, ".data"}, rd_data[p], ed);
        chk({nm, ".busy"}, XLEN'(rd_busy[p]), XLEN'(eb));
        chk({nm, ".tag"},  XLEN'(rd_tag[p]),  XLEN'(et));
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_tag   = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
        flush     = 1'b0;
    endtask

    task automatic issue(input int r, input int t);
        iss_valid = 1'b1;
        iss_rd    = AW'(r);
        iss_tag   = TAG_W'(t);
    endtask

    task automatic cdb(input int k, input int t, input logic [XLEN-1:0] d);
        cdb_valid[k] = 1'b1;
        cdb_tag[k]   = TAG_W'(t);
        cdb_data[k]  = d;
    endtask

    initial begin
        idle();
        rd_addr  = '0;
        dbg_addr = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk_rd("reset", p, p * 7 + 1, 32'h0, 1'b0, 4'h0);
        end
        dbg_addr = AW'(13);
        #1 chk("reset.dbg", dbg_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rename x5 to tag 3, then resolve it on CDB port 1.
        issue(5, 3);
        tick();
        idle();
        chk_rd("x5_pending", 0, 5, 32'h0, 1'b1, 4'd3);
        cdb(1, 3, 32'hDEADBEEF);
        tick();
        idle();
        chk_rd("x5_done", 0, 5, 32'hDEADBEEF, 1'b0, 4'd0);
        dbg_addr = AW'(5);
        #1 chk("x5_dbg", dbg_data, 32'hDEADBEEF);

        // Capture and re-rename of x7 in the same cycle.
        issue(7, 2);
        tick();
        idle();
        cdb(0, 2, 32'h11);
        issue(7, 9);
        tick();
        idle();
        chk_rd("x7_cap_reiss", 1, 7, 32'h11, 1'b1, 4'd9);
        cdb(0, 2, 32'h22);
        tick();
        idle();
        chk_rd("x7_stale_tag", 1, 7, 32'h11, 1'b1, 4'd9);

        // Two ports with the same tag: port 0 has priority.
        issue(3, 4);
        tick();
        idle();
        cdb(0, 4, 32'hAA);
        cdb(1, 4, 32'hBB);
        tick();
        idle();
        chk_rd("x3_prio", 2, 3, 32'hAA, 1'b0, 4'd0);

        // Register 0 ignores issue and CDB.
        issue(0, 1);
        cdb(0, 1, 32'h77);
        tick();
        idle();
        chk_rd("x0_fixed", 3, 0, 32'h0, 1'b0, 4'd0);

        // Give x9 a known value, then rename it to tag 6.
        issue(9, 5);
        tick();
        idle();
        cdb(1, 5, 32'h99);
        tick();
        idle();
        chk_rd("x9_val", 0, 9, 32'h99, 1'b0, 4'd0);
        issue(9, 6);
        tick();
        idle();

        // Same-cycle read of busy x9 while tag 6 is on the CDB.
        cdb(0, 6, 32'h55);
`ifdef REGFILE_CDB_BYPASS_EN
        chk_rd("x9_bypass", 0, 9, 32'h55, 1'b0, 4'd0);
`else
        chk_rd("x9_nobypass", 0, 9, 32'h99, 1'b1, 4'd6);
`endif
        // With flush asserted the read sees stored state only.
        flush = 1'b1;
        chk_rd("x9_flush_rd", 0, 9, 32'h99, 1'b1, 4'd6);
        tick();
        idle();
        chk_rd("x9_flushed", 0, 9, 32'h99, 1'b0, 4'd0);
        chk_rd("x7_flushed", 1, 7, 32'h11, 1'b0, 4'd0);

        // Parallel reads on all ports after the sequence.
        rd_addr[0] = AW'(5);
        rd_addr[1] = AW'(3);
        rd_addr[2] = AW'(7);
        rd_addr[3] = AW'(9);
        #1;
        chk("par.p0", rd_data[0], 32'hDEADBEEF);
        chk("par.p1", rd_data[1], 32'hAA);
        chk("par.p2", rd_data[2], 32'h11);
        chk("par.p3", rd_data[3], 32'h99);

        // Mid-operation asynchronous reset clears everything immediately.
        issue(12, 7);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk_rd("areset_x12", 0, 12, 32'h0, 1'b0, 4'd0);
        chk_rd("areset_x5", 1, 5, 32'h0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
